// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SEG_W-bit segment per stage.
// Optional signed saturation on overflow when CLA_PIPE_SAT_EN is defined.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSEG = WIDTH / SEG_W;
    localparam int unsigned NG   = SEG_W / 4;

    // Carries c[j] into position j from propagate/generate, fully expanded (no ripple).
    function automatic logic [4:0] la4(input logic [3:0] p, input logic [3:0] g, input logic c0);
        logic [4:0] c;
        logic       t;
        c[0] = c0;
        for (int unsigned j = 1; j <= 4; j++) begin
            t = c0;
            for (int unsigned i = 0; i < j; i++) t = t & p[i];
            c[j] = t;
            for (int unsigned i = 0; i < j; i++) begin
                t = g[i];
                for (int unsigned m = i + 1; m < j; m++) t = t & p[m];
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

    function automatic logic [NG:0] la_grp(input logic [NG-1:0] pm, input logic [NG-1:0] gm, input logic c0);
        logic [NG:0] c;
        logic        t;
        c[0] = c0;
        for (int unsigned j = 1; j <= NG; j++) begin
            t = c0;
            for (int unsigned i = 0; i < j; i++) t = t & pm[i];
            c[j] = t;
            for (int unsigned i = 0; i < j; i++) begin
                t = gm[i];
                for (int unsigned m = i + 1; m < j; m++) t = t & pm[m];
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

    // Returns {carry_out, sum} for one segment built from 4-bit CLA groups.
    function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] x, input logic [SEG_W-1:0] y,
                                               input logic c0);
        logic [SEG_W-1:0] p, g, c;
        logic [NG-1:0]    pm, gm;
        logic [NG:0]      gc;
        logic [4:0]       c4;
        p = x ^ y;
        g = x & y;
        for (int unsigned j = 0; j < NG; j++) begin
            c4    = la4(p[4*j +: 4], g[4*j +: 4], 1'b0);
            pm[j] = &p[4*j +: 4];
            gm[j] = c4[4];
        end
        gc = la_grp(pm, gm, c0);
        for (int unsigned j = 0; j < NG; j++) begin
            c4         = la4(p[4*j +: 4], g[4*j +: 4], gc[j]);
            c[4*j +: 4] = c4[3:0];
        end
        return {gc[NG], p ^ c};
    endfunction

    logic [NSEG-1:0]  vld_q, cry_q, v_in, c_in, cry_d;
    logic [WIDTH-1:0] sum_q [NSEG];
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic [WIDTH-1:0] a_in  [NSEG];
    logic [WIDTH-1:0] b_in  [NSEG];
    logic [WIDTH-1:0] sum_in[NSEG];
    logic [WIDTH-1:0] sum_d [NSEG];
    logic             ovf_q, ovf_d, stall;

    assign stall     = vld_q[NSEG-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[NSEG-1];
    assign s         = sum_q[NSEG-1];
    assign cout      = cry_q[NSEG-1];
    assign ovf       = ovf_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG_W:0]   seg;
        logic [WIDTH-1:0] sum_nx;

        if (k == 0) begin : g_in
            assign a_in[k]   = a;
            assign b_in[k]   = op ? ~b : b;
            assign c_in[k]   = op | cin;
            assign sum_in[k] = '0;
            assign v_in[k]   = in_valid;
        end else begin : g_pipe
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = cry_q[k-1];
            assign sum_in[k] = sum_q[k-1];
            assign v_in[k]   = vld_q[k-1];
        end

        assign seg      = cla_seg(a_in[k][k*SEG_W +: SEG_W], b_in[k][k*SEG_W +: SEG_W], c_in[k]);
        assign cry_d[k] = seg[SEG_W];

        always_comb begin
            sum_nx = sum_in[k];
            sum_nx[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
        end

        if (k == NSEG - 1) begin : g_out
            // Carry into the MSB is recovered as a^b^sum at that bit.
            assign ovf_d = a_in[k][WIDTH-1] ^ b_in[k][WIDTH-1] ^ sum_nx[WIDTH-1] ^ seg[SEG_W];
`ifdef CLA_PIPE_SAT_EN
            assign sum_d[k] = !ovf_d ? sum_nx :
                              a_in[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign sum_d[k] = sum_nx;
`endif
        end else begin : g_mid
            assign sum_d[k] = sum_nx;
        end
    end

    // Whole pipeline, bubbles included, freezes while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < NSEG; i++) begin
                sum_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
            end
        end else if (!stall) begin
            vld_q <= v_in;
            cry_q <= cry_d;
            ovf_q <= ovf_d;
            for (int unsigned i = 0; i < NSEG; i++) begin
                sum_q[i] <= sum_d[i];
                a_q[i]   <= a_in[i];
                b_q[i]   <= b_in[i];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: arithmetic reference model, queued expectations,
// independent monitor checking data, latency, back-pressure and reset flush.
module tb_cla_pipe_adder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEG_W = 8;
    localparam int unsigned LAT   = WIDTH / SEG_W;

    logic             clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, op = 1'b0, out_ready = 1'b1;
    logic             in_ready, out_valid, cout, ovf;
    logic [WIDTH-1:0] a = '0, b = '0, s;

    cla_pipe_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int unsigned cyc;
        int unsigned stl;
    } exp_t;

    exp_t        q[$];
    int unsigned tests = 0, failed = 0, cycle = 0, stall_cnt = 0;
    bit          held = 1'b0, rst_prev = 1'b0, rnd_done = 1'b0;

    function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb, input logic xc, input logic xop);
        exp_t        e;
        logic [31:0] be;
        logic [32:0] wide;
        longint      r;
        be     = xop ? ~xb : xb;
        wide   = {1'b0, xa} + {1'b0, be} + (xop ? 33'd1 : {32'd0, xc});
        r      = longint'($signed(xa)) + longint'($signed(be)) + ((xop || xc) ? 64'sd1 : 64'sd0);
        e.s    = wide[31:0];
        e.cout = wide[32];
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef CLA_PIPE_SAT_EN
        if (e.ovf) e.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor samples on the falling edge, between the driver's updates and the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (rst_prev) check("out_valid_after_reset", 64'(out_valid), 64'd0);
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (!rst_n) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_output: got s=%0h expected no output", s);
                end else begin
                    check("s", 64'(s), 64'(q[0].s));
                    check("cout", 64'(cout), 64'(q[0].cout));
                    check("ovf", 64'(ovf), 64'(q[0].ovf));
                    if (!held)
                        check("latency", 64'(cycle), 64'(q[0].cyc + LAT + (stall_cnt - q[0].stl)));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e     = model(a, b, cin, op);
                e.cyc = cycle;
                e.stl = stall_cnt;
                q.push_back(e);
            end
            held = out_valid && !out_ready;
            if (held) stall_cnt++;
        end
        rst_prev = !rst_n;
    end

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xc, input logic xop);
        int unsigned n = 0;
        a = xa; b = xb; cin = xc; op = xop; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2 in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_s", 64'(s), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain();
        send(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        drain();

        fork
            for (int i = 0; i < 8; i++) send(32'(i), 32'(16 * i), 1'b0, 1'b0);
            begin
                int unsigned n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_first_valid", 64'(out_valid), 64'd1);
                @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        send(32'd10, 32'd20, 1'b0, 1'b0);
        send(32'd30, 32'd40, 1'b0, 1'b0);
        send(32'd50, 32'd60, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        send(32'd2, 32'd3, 1'b0, 1'b0);
        drain();

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #2;
                    end
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk);
                #2 out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit CLA cell.
- Operand is split into NSEG = WIDTH/SEG_W segments, one segment per pipeline stage. Each stage is built from 4-bit CLA groups. A registered carry ripples between stages.
- Valid/ready handshake on input and output, full back-pressure. Used as the shared integer add datapath in the arithmetic unit.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG_W.
- SEG_W, 8, bits summed per pipeline stage; must be a multiple of 4 (4-bit CLA groups).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand transaction valid
- in_ready  output  1  block accepts transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, add mode only
- op  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+1, cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out of MSB; in subtract mode 1 = no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: all stage valid bits 0, out_valid 0, s 0, cout 0, ovf 0. Operand skew registers are cleared to 0.
- Reset mid-operation: in-flight transactions are discarded and never emitted. out_valid is 0 in the cycle after rst_n is sampled low.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid must not depend on in_ready; out_valid must not depend on out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall (combinational, registered inputs only plus out_ready).
  - While stalled, every stage register holds, including empty bubbles. Bubbles are not compressed.
  - s/cout/ovf are stable while out_valid && !out_ready.
- Stage 0:
  - Latches segment 0 of a and b; b is inverted when op=1.
  - Carry-in is cin when op=0, else 1.
  - Computes bits [SEG_W-1:0] and segment carry.
  - Stores upper operand bits, op and valid in skew registers.
- Stage k, for 1..NSEG-1:
  - Adds bits [k*SEG_W +: SEG_W] using the registered carry from stage k-1.
  - Forwards lower result bits unchanged.
  - Within a stage, group carries are computed by lookahead (p/g per bit, group pm/gm, second-level lookahead across groups); no bit-level ripple.
- Latency: exactly NSEG cycles from input transfer to out_valid when no stall occurs. Throughput is 1 transaction per cycle.
- Final stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - ovf is computed on the effective operand (~b in subtract mode).
- Wrap-around: results are modulo 2^WIDTH unless the optional feature is enabled.
- Simultaneous events: input and output transfer in the same cycle is legal; the pipeline advances by one. Ordering is strictly FIFO.
- Degenerate case: NSEG=1 gives a single registered stage with latency 1.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- Defined: final-stage signed saturation when ovf=1. s is 0x7FF..F if the MSB of both effective operands is 0, and 0x800..0 if both are 1. ovf is still reported. cout is unchanged.
- Undefined: no saturation logic; s wraps modulo 2^WIDTH.

Test Plan:
All scenarios use WIDTH=32, SEG_W=8 (latency 4).
1. add 0xFFFFFFFF + 0x00000001, cin=0 -> 4 cycles later s=0x00000000, cout=1, ovf=0.
2. add 0x000000FF + 0x00000000, cin=1 -> s=0x00000100, cout=0; checks the carry across the segment boundary.
3. add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, ovf=1. With CLA_PIPE_SAT_EN: s=0x7FFFFFFF, ovf=1.
4. sub 0x00000005 - 0x00000007 (op=1, cin=1 ignored) -> s=0xFFFFFFFE, cout=0, ovf=0. Then sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, ovf=1; with SAT: s=0x80000000.
5. Back-to-back inputs i=0..7 (a=i, b=0x10*i, op=0). out_ready held low for 3 cycles once the first result is valid -> in_ready=0 during the stall, s held stable, all 8 results s=0x11*i delivered in order, no duplicates or losses.
6. Three transactions in flight, rst_n low for 1 cycle -> out_valid=0 next cycle; none of the three is ever emitted; a fresh add 2+3 afterwards gives s=5 after 4 cycles.
